// File: rtl/clk_burst_pkg.sv
// Shared types and widths for the clock-burst scheduler.
package clk_burst_pkg;

   localparam int DIV_W = 5;
   localparam int LEN_W = 8;
   localparam int NREQ  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_RUN   = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   function automatic logic [NREQ-1:0] req_onehot(input logic idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/burst_div.sv
// Divide counter, clk_out toggle and remaining-period count for one burst.
module burst_div
   import clk_burst_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] div,
   input  logic [LEN_W-1:0] len,
   output logic             clk_out,
   output logic             last
);

   logic             r_active;
   logic [DIV_W-1:0] r_cnt;
   logic [LEN_W-1:0] r_remain;
   logic             r_clk;
   logic             w_wrap;
   logic             w_fall;

   assign w_wrap  = r_active && (r_cnt == div);
   assign w_fall  = w_wrap && r_clk;
   // High in the cycle whose closing edge makes the final falling toggle.
   assign last    = w_fall && (r_remain == LEN_W'(1));
   assign clk_out = r_clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active <= 1'b0;
         r_cnt    <= '0;
         r_remain <= '0;
         r_clk    <= 1'b0;
      end else if (start) begin
         r_active <= (len != '0);
         r_cnt    <= '0;
         r_remain <= len;
         r_clk    <= 1'b0;
      end else if (r_active) begin
         if (w_wrap) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
            if (r_clk) begin
               r_remain <= r_remain - LEN_W'(1);
               if (r_remain == LEN_W'(1))
                  r_active <= 1'b0;
            end
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/clk_burst_sched.sv
// Round-robin scheduler granting bursts of a divided clock to two requesters.
module clk_burst_sched
   import clk_burst_pkg::*;
#(
   parameter int GAP_CYC = 2
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic [DIV_W-1:0] div0,
   input  logic [DIV_W-1:0] div1,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   output logic [NREQ-1:0]  gnt,
   output logic [NREQ-1:0]  done,
   output logic             clk_out,
   output logic             busy
);

   // A zero gap still spends one cycle in GAP so done has a slot.
   localparam int         GAP_LEN  = (GAP_CYC < 1) ? 1 : GAP_CYC;
   localparam logic [3:0] GAP_LAST = 4'(GAP_LEN - 1);

   state_t           r_state;
   logic             r_win;
   logic             r_rr_ptr;
   logic [DIV_W-1:0] r_div;
   logic [LEN_W-1:0] r_len;
   logic [3:0]       r_gap_cnt;

   logic [DIV_W-1:0] w_div_arr [NREQ];
   logic [LEN_W-1:0] w_len_arr [NREQ];
   logic             w_win;
   logic             w_start;
   logic             w_last;

   assign w_div_arr[0] = div0;
   assign w_div_arr[1] = div1;
   assign w_len_arr[0] = len0;
   assign w_len_arr[1] = len1;

   // Contention goes to the pointer; a lone request wins outright.
   assign w_win   = (req == 2'b11) ? r_rr_ptr : req[1];
   assign w_start = (r_state == ST_GRANT);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_win     <= 1'b0;
         r_rr_ptr  <= 1'b0;
         r_div     <= '0;
         r_len     <= '0;
         r_gap_cnt <= '0;
         gnt       <= '0;
         done      <= '0;
         busy      <= 1'b0;
      end else begin
         gnt  <= '0;
         done <= '0;
         case (r_state)
            ST_IDLE: begin
               if (req != '0) begin
                  r_win    <= w_win;
                  r_rr_ptr <= ~w_win;
                  r_div    <= w_div_arr[w_win];
                  r_len    <= w_len_arr[w_win];
                  gnt      <= req_onehot(w_win);
                  busy     <= 1'b1;
                  r_state  <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (r_len == '0) begin
                  done      <= req_onehot(r_win);
                  r_gap_cnt <= '0;
                  r_state   <= ST_GAP;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_last) begin
                  done      <= req_onehot(r_win);
                  r_gap_cnt <= '0;
                  r_state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  busy    <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 4'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   burst_div u_div (
      .clk     (clk_in),
      .rst     (rst),
      .start   (w_start),
      .div     (r_div),
      .len     (r_len),
      .clk_out (clk_out),
      .last    (w_last)
   );

endmodule
